// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared encodings and constants for the MEM stage
package mem_stage_pkg;

  typedef enum logic [1:0] {
    SIZE_NONE = 2'd0,
    SIZE_BYTE = 2'd1,
    SIZE_HALF = 2'd2,
    SIZE_WORD = 2'd3
  } access_size_t;

  function automatic int mem_depth(input int addr_size);
    return 2 ** addr_size;
  endfunction

  localparam int MEM_ADDR_SIZE_DEFAULT = 6;
  localparam int MEM_DEPTH = mem_depth(MEM_ADDR_SIZE_DEFAULT);

  typedef struct packed {
    logic         is_signed;
    logic         reg_write;
    logic         mem_to_reg;
    logic         mem_read;
    logic         mem_write;
    logic         branch;
    logic         zero;
    logic         halt;
    logic         jump;
    logic         last_register_ctrl;
    access_size_t size;
  } ex_ctrl_t;

  // All-zero control word is a bubble: no register write, no memory access.
  localparam ex_ctrl_t NOP_CTRL = '0;

  // One-hot size enables collapse to an encoding; no enable means no access.
  function automatic access_size_t encode_size(input logic b, input logic h, input logic w);
    if (b) return SIZE_BYTE;
    if (h) return SIZE_HALF;
    if (w) return SIZE_WORD;
    return SIZE_NONE;
  endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// rtl/mem_stage_data_memory.sv - byte-lane writable data memory with pipeline and debug read ports
module mem_stage_data_memory
  import mem_stage_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 6,
  localparam int LANES = DATA_SIZE / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LANES-1:0]     lane_we,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [DATA_SIZE-1:0] wdata,
  output logic [DATA_SIZE-1:0] rdata,
  input  logic [ADDR_SIZE-1:0] debug_addr,
  output logic [DATA_SIZE-1:0] debug_data
);

  localparam int DEPTH = mem_depth(ADDR_SIZE);

  logic [DATA_SIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int l = 0; l < LANES; l++)
        if (lane_we[l]) mem[addr][8*l +: 8] <= wdata[8*l +: 8];
    end
  end

  assign rdata      = mem[addr];
  assign debug_data = mem[debug_addr];

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - EX/MEM latch, data memory access, load formatting and branch decision
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_SIZE     = 32,
  parameter int PC_SIZE       = 32,
  parameter int REG_SIZE      = 5,
  parameter int MEM_ADDR_SIZE = 6
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic                     i_signed,
  input  logic                     i_reg_write,
  input  logic                     i_mem_to_reg,
  input  logic                     i_mem_read,
  input  logic                     i_mem_write,
  input  logic                     i_branch,
  input  logic                     i_zero,
  input  logic                     i_halt,
  input  logic                     i_jump,
  input  logic                     i_byte_enable,
  input  logic                     i_halfword_enable,
  input  logic                     i_word_enable,
  input  logic [DATA_SIZE-1:0]     i_alu_result,
  input  logic [DATA_SIZE-1:0]     i_data_b,
  input  logic [REG_SIZE-1:0]      i_selected_reg,
  input  logic [PC_SIZE-1:0]       i_branch_addr,
  input  logic [PC_SIZE-1:0]       i_pc,
  input  logic                     i_last_register_ctrl,
  input  logic [MEM_ADDR_SIZE-1:0] i_debug_addr,
  output logic [DATA_SIZE-1:0]     o_read_data,
  output logic [DATA_SIZE-1:0]     o_alu_result,
  output logic [REG_SIZE-1:0]      o_selected_reg,
  output logic                     o_reg_write,
  output logic                     o_mem_to_reg,
  output logic                     o_last_register_ctrl,
  output logic                     o_halt,
  output logic [PC_SIZE-1:0]       o_pc,
  output logic                     o_pc_src,
  output logic [PC_SIZE-1:0]       o_branch_addr,
  output logic                     o_misaligned,
  output logic [DATA_SIZE-1:0]     o_debug_data
);

  localparam int LANES = DATA_SIZE / 8;

  ex_ctrl_t             ctrl_q;
  logic [DATA_SIZE-1:0] alu_q;
  logic [DATA_SIZE-1:0] data_b_q;
  logic [REG_SIZE-1:0]  reg_q;
  logic [PC_SIZE-1:0]   branch_addr_q;
  logic [PC_SIZE-1:0]   pc_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ctrl_q        <= NOP_CTRL;
      alu_q         <= '0;
      data_b_q      <= '0;
      reg_q         <= '0;
      branch_addr_q <= '0;
      pc_q          <= '0;
    end else if (i_enable) begin
      ctrl_q.is_signed          <= i_signed;
      ctrl_q.reg_write          <= i_reg_write;
      ctrl_q.mem_to_reg         <= i_mem_to_reg;
      ctrl_q.mem_read           <= i_mem_read;
      ctrl_q.mem_write          <= i_mem_write;
      ctrl_q.branch             <= i_branch;
      ctrl_q.zero               <= i_zero;
      ctrl_q.halt               <= i_halt;
      ctrl_q.jump               <= i_jump;
      ctrl_q.last_register_ctrl <= i_last_register_ctrl;
      ctrl_q.size               <= encode_size(i_byte_enable, i_halfword_enable, i_word_enable);
      alu_q                     <= i_alu_result;
      data_b_q                  <= i_data_b;
      reg_q                     <= i_selected_reg;
      branch_addr_q             <= i_branch_addr;
      pc_q                      <= i_pc;
    end
  end

  logic [1:0]               offset;
  logic                     misaligned;
  logic [LANES-1:0]         lane_mask;
  logic [LANES-1:0]         lane_we;
  logic [DATA_SIZE-1:0]     wdata;
  logic [DATA_SIZE-1:0]     rword;
  logic [DATA_SIZE-1:0]     formatted;
  logic [7:0]               sel_byte;
  logic [15:0]              sel_half;
  logic [MEM_ADDR_SIZE-1:0] word_index;

  assign offset     = alu_q[1:0];
  assign word_index = alu_q[MEM_ADDR_SIZE+1:2];
  assign misaligned = (ctrl_q.mem_read | ctrl_q.mem_write) &
                      (((ctrl_q.size == SIZE_HALF) & offset[0]) |
                       ((ctrl_q.size == SIZE_WORD) & (offset != 2'b00)));

  // Store data is replicated across lanes so the lane mask alone picks the target bytes.
  always_comb begin
    lane_mask = '0;
    wdata     = data_b_q;
    case (ctrl_q.size)
      SIZE_BYTE: begin
        lane_mask = LANES'(1) << offset;
        wdata     = {(DATA_SIZE/8){data_b_q[7:0]}};
      end
      SIZE_HALF: begin
        lane_mask = LANES'(3) << {offset[1], 1'b0};
        wdata     = {(DATA_SIZE/16){data_b_q[15:0]}};
      end
      SIZE_WORD: lane_mask = '1;
      default:   lane_mask = '0;
    endcase
  end

  assign lane_we = (ctrl_q.mem_write & i_enable & ~misaligned) ? lane_mask : '0;

  mem_stage_data_memory #(
    .DATA_SIZE(DATA_SIZE),
    .ADDR_SIZE(MEM_ADDR_SIZE)
  ) u_data_memory (
    .clk       (i_clk),
    .rst       (i_reset),
    .lane_we   (lane_we),
    .addr      (word_index),
    .wdata     (wdata),
    .rdata     (rword),
    .debug_addr(i_debug_addr),
    .debug_data(o_debug_data)
  );

  assign sel_byte = rword[8*offset +: 8];
  assign sel_half = rword[16*offset[1] +: 16];

  always_comb begin
    formatted = '0;
    case (ctrl_q.size)
      SIZE_BYTE: formatted = {{(DATA_SIZE-8){ctrl_q.is_signed & sel_byte[7]}}, sel_byte};
      SIZE_HALF: formatted = {{(DATA_SIZE-16){ctrl_q.is_signed & sel_half[15]}}, sel_half};
      SIZE_WORD: formatted = rword;
      default:   formatted = '0;
    endcase
  end

  assign o_read_data          = (ctrl_q.mem_read & ~misaligned) ? formatted : '0;
  assign o_alu_result         = alu_q;
  assign o_selected_reg       = reg_q;
  assign o_reg_write          = ctrl_q.reg_write;
  assign o_mem_to_reg         = ctrl_q.mem_to_reg;
  assign o_last_register_ctrl = ctrl_q.last_register_ctrl;
  assign o_halt               = ctrl_q.halt;
  assign o_pc                 = pc_q;
  assign o_pc_src             = ctrl_q.branch & ctrl_q.zero;
  assign o_branch_addr        = branch_addr_q;
  assign o_misaligned         = misaligned;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline.
- Contains the EX/MEM pipeline register, the byte-addressable data memory with byte, halfword and word access, load sign/zero extension, and the branch-taken decision.
- Consumes the EX stage outputs. Feeds the MEM/WB latch and the forwarding unit, and drives the PC source to IF. A debug read port lets the debug unit dump memory.

Parameters:
- DATA_SIZE, 32, data path width
- PC_SIZE, 32, PC/branch address width
- REG_SIZE, 5, register index width
- MEM_ADDR_SIZE, 6, word-address bits; depth = 2**MEM_ADDR_SIZE words

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous active-high reset
- i_enable  in  1  pipeline advance (debug step/run); 0 = freeze latch and memory
- i_signed, i_reg_write, i_mem_to_reg, i_mem_read, i_mem_write, i_branch, i_zero, i_halt, i_jump  in  1 each  EX control/status
- i_byte_enable, i_halfword_enable, i_word_enable  in  1 each  access size (one-hot or all 0)
- i_alu_result  in  DATA_SIZE  byte address / ALU value
- i_data_b  in  DATA_SIZE  store data (already forwarded)
- i_selected_reg  in  REG_SIZE  destination register
- i_branch_addr, i_pc  in  PC_SIZE  branch target, return PC
- i_last_register_ctrl  in  1  JAL/JALR link select
- i_debug_addr  in  MEM_ADDR_SIZE  debug word index
- o_read_data  out  DATA_SIZE  formatted load data
- o_alu_result  out  DATA_SIZE  latched ALU result (also MEM forwarding data)
- o_selected_reg  out  REG_SIZE  latched destination
- o_reg_write, o_mem_to_reg, o_last_register_ctrl, o_halt  out  1 each  latched flags
- o_pc  out  PC_SIZE  latched PC
- o_pc_src  out  1  branch taken
- o_branch_addr  out  PC_SIZE  latched branch target
- o_misaligned  out  1  current access misaligned
- o_debug_data  out  DATA_SIZE  memory word at i_debug_addr

Behaviour:
- EX/MEM latch:
  - Async reset clears every latched field to 0, which is a NOP bubble.
  - On posedge with i_enable=1, captures all i_* EX fields. With i_enable=0, holds.
- Memory:
  - Array of depth x DATA_SIZE. Reset clears every word to 0.
  - Word index = latched alu_result[MEM_ADDR_SIZE+1:2]; upper bits ignored, so addresses wrap modulo depth.
- Write:
  - Occurs on the posedge after latching, when latched mem_write=1, i_enable=1 and the access is not misaligned.
  - Byte: lane addr[1:0] gets data_b[7:0].
  - Halfword: lane addr[1] gets data_b[15:0].
  - Word: full word.
  - Unselected lanes are unchanged.
  - Write with no size enable set: no write.
- Misalignment:
  - o_misaligned=1 when (halfword and addr[0]) or (word and addr[1:0]!=0), and latched mem_read or mem_write is set.
  - A misaligned store does not write. A misaligned load returns 0.
- Read:
  - Combinational from the array at the latched index.
  - Byte: selected lane, sign-extended if latched signed=1, else zero-extended. Halfword likewise.
  - Word: unchanged.
  - o_read_data=0 when latched mem_read=0.
- Read-during-write to the same word in the same cycle: o_read_data shows the old contents; the new value is visible after the edge.
- o_pc_src = latched branch & latched zero. Combinational; 0 after reset.
- Latency: EX inputs appear on the o_* outputs 1 cycle after the enabled edge. Store data lands in the array 1 further enabled edge later.
- Halt: o_halt follows the latched i_halt. After halt, the stage keeps operating under i_enable; the debug unit deasserts enable.
- o_debug_data: combinational read at i_debug_addr, independent of i_enable.
- Reset mid-operation clears the latch and memory immediately; all outputs go to 0.

Decomposition:
- Shared package holds:
  - access-size encodings
  - MEM_DEPTH = 2**MEM_ADDR_SIZE
  - NOP latch value
- One sub-module, data_memory: array, byte-lane write enables, reset, two read ports (pipeline and debug).
- The latch and load formatting stay in mem_stage.

Test Plan:
- Reset, then all inputs 0 with enable=1 -> all outputs 0, o_pc_src=0, o_debug_data=0 for every index.
- SW data_b=0xDEADBEEF at addr 0x8, then LW addr 0x8 -> o_read_data=0xDEADBEEF; o_debug_data at index 2 = 0xDEADBEEF.
- SB 0x80 at addr 0x5 over word 0 -> word 1 = 0x00008000; LB signed at 0x5 -> 0xFFFFFF80; LBU -> 0x00000080.
- SH 0x1234 at addr 0x2 -> word 0 = 0x12340000; SH at addr 0x3 -> o_misaligned=1, memory unchanged; LH at 0x3 -> 0.
- branch=1, zero=1, branch_addr=0x40 -> o_pc_src=1 and o_branch_addr=0x40 one cycle after capture; with zero=0 -> o_pc_src=0.
- SW issued with enable=0, then reset asserted mid-sequence -> no write occurs; after reset, all memory is 0 and the latch holds a NOP.
